// File: rtl/player_motion.sv
// Position owner for both players: vertical moves from jump-controller pulses,
// rate-divided horizontal moves from held inputs, arena clamping and anti-overlap.
module player_motion #(
   parameter int unsigned STEP_Y   = 1,
   parameter int unsigned Y_MIN    = 100,
   parameter int unsigned Y_MAX    = 180,
   parameter int unsigned X_MIN    = 0,
   parameter int unsigned X_MAX    = 620,
   parameter int unsigned P1_X0    = 100,
   parameter int unsigned P2_X0    = 500,
   parameter int unsigned MOVE_DIV = 500000,
   parameter int unsigned PLAYER_W = 20,
   parameter int unsigned PLAYER_H = 40
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        p1_up_cmd,
   input  logic        p1_drop_cmd,
   input  logic        p2_up_cmd,
   input  logic        p2_drop_cmd,
   input  logic        p1_l,
   input  logic        p1_r,
   input  logic        p2_l,
   input  logic        p2_r,
   output logic [15:0] p1_x,
   output logic [15:0] p1_y,
   output logic [15:0] p2_x,
   output logic [15:0] p2_y,
   output logic        p1_on_ground,
   output logic        p2_on_ground,
   output logic        p1_facing,
   output logic        p2_facing
);

   localparam int unsigned POS_W = 16;
   localparam int unsigned CNT_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

   typedef enum logic [1:0] {
      DIR_NONE  = 2'd0,
      DIR_LEFT  = 2'd1,
      DIR_RIGHT = 2'd2
   } dir_e;

   dir_e             p1_dir_q, p2_dir_q;
   dir_e             p1_dir, p2_dir;
   logic [CNT_W-1:0] p1_cnt, p2_cnt, p1_cnt_d, p2_cnt_d;
   logic [POS_W-1:0] p1_x_d, p2_x_d, p1_y_d, p2_y_d;
   logic [POS_W-1:0] p1_cand, p2_cand;
   logic             p1_fire, p2_fire;
   logic             p1_facing_d, p2_facing_d;

   function automatic dir_e decode_dir(input logic l, input logic r);
      if (l && !r) return DIR_LEFT;
      if (r && !l) return DIR_RIGHT;
      return DIR_NONE;
   endfunction

   function automatic logic [POS_W-1:0] abs_diff(input logic [POS_W-1:0] a,
                                                 input logic [POS_W-1:0] b);
      return (a > b) ? a - b : b - a;
   endfunction

   function automatic logic [POS_W-1:0] next_y(input logic [POS_W-1:0] y,
                                               input logic up, input logic drop);
      if (up && !drop)
         return (y < POS_W'(Y_MIN + STEP_Y)) ? POS_W'(Y_MIN) : y - POS_W'(STEP_Y);
      if (drop && !up)
         return (y > POS_W'(Y_MAX - STEP_Y)) ? POS_W'(Y_MAX) : y + POS_W'(STEP_Y);
      return y;
   endfunction

   // Wall clamp: at a wall the candidate equals the current x.
   function automatic logic [POS_W-1:0] step_x(input logic [POS_W-1:0] x, input dir_e dir);
      case (dir)
         DIR_RIGHT: return (x < POS_W'(X_MAX)) ? x + POS_W'(1) : x;
         DIR_LEFT:  return (x > POS_W'(X_MIN)) ? x - POS_W'(1) : x;
         default:   return x;
      endcase
   endfunction

   // Suppress only moves that land in overlap and close the horizontal gap.
   function automatic logic blocked(input logic [POS_W-1:0] cand, input logic [POS_W-1:0] x,
                                    input logic [POS_W-1:0] ox, input logic [POS_W-1:0] y,
                                    input logic [POS_W-1:0] oy);
      return (abs_diff(cand, ox) < POS_W'(PLAYER_W)) &&
             (abs_diff(y, oy) < POS_W'(PLAYER_H)) &&
             (abs_diff(cand, ox) < abs_diff(x, ox));
   endfunction

   // Next-state logic; p2's overlap test sees p1's post-edge x so p1 wins ties.
   always_comb begin
      p1_dir      = decode_dir(p1_l, p1_r);
      p2_dir      = decode_dir(p2_l, p2_r);
      p1_fire     = (p1_dir != DIR_NONE) && (p1_dir == p1_dir_q) &&
                    (p1_cnt == CNT_W'(MOVE_DIV - 1));
      p2_fire     = (p2_dir != DIR_NONE) && (p2_dir == p2_dir_q) &&
                    (p2_cnt == CNT_W'(MOVE_DIV - 1));
      p1_cnt_d    = p1_cnt + CNT_W'(1);
      p2_cnt_d    = p2_cnt + CNT_W'(1);
      p1_cand     = step_x(p1_x, p1_dir);
      p2_cand     = step_x(p2_x, p2_dir);
      p1_x_d      = p1_x;
      p2_x_d      = p2_x;
      p1_y_d      = next_y(p1_y, p1_up_cmd, p1_drop_cmd);
      p2_y_d      = next_y(p2_y, p2_up_cmd, p2_drop_cmd);
      p1_facing_d = p1_facing;
      p2_facing_d = p2_facing;

      if (p1_dir == DIR_NONE || p1_dir != p1_dir_q || p1_fire) p1_cnt_d = '0;
      if (p2_dir == DIR_NONE || p2_dir != p2_dir_q || p2_fire) p2_cnt_d = '0;

      if (p1_fire && !blocked(p1_cand, p1_x, p2_x, p1_y, p2_y)) p1_x_d = p1_cand;
      if (p2_fire && !blocked(p2_cand, p2_x, p1_x_d, p2_y, p1_y)) p2_x_d = p2_cand;

      if (p1_dir == DIR_RIGHT) p1_facing_d = 1'b1;
      else if (p1_dir == DIR_LEFT) p1_facing_d = 1'b0;
      if (p2_dir == DIR_RIGHT) p2_facing_d = 1'b1;
      else if (p2_dir == DIR_LEFT) p2_facing_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         p1_x      <= POS_W'(P1_X0);
         p2_x      <= POS_W'(P2_X0);
         p1_y      <= POS_W'(Y_MAX);
         p2_y      <= POS_W'(Y_MAX);
         p1_facing <= 1'b1;
         p2_facing <= 1'b0;
         p1_cnt    <= '0;
         p2_cnt    <= '0;
         p1_dir_q  <= DIR_NONE;
         p2_dir_q  <= DIR_NONE;
      end else begin
         p1_x      <= p1_x_d;
         p2_x      <= p2_x_d;
         p1_y      <= p1_y_d;
         p2_y      <= p2_y_d;
         p1_facing <= p1_facing_d;
         p2_facing <= p2_facing_d;
         p1_cnt    <= p1_cnt_d;
         p2_cnt    <= p2_cnt_d;
         p1_dir_q  <= p1_dir;
         p2_dir_q  <= p2_dir;
      end
   end

   assign p1_on_ground = (p1_y == POS_W'(Y_MAX));
   assign p2_on_ground = (p2_y == POS_W'(Y_MAX));

endmodule
